spike_encoder: RTL

//  Rate-codes the stored 14x14 input image into one Bernoulli spike per pixel per timestep, feeding the spike queue.

---
 rtl/spike_encoder.sv | 100 ++++++++++
 1 files changed

// File: rtl/spike_encoder.sv
// Rate encoder: turns each stored pixel into one Bernoulli spike per timestep by comparing the
// pixel intensity against an LFSR sample, then offers the spike to the downstream queue.
module spike_encoder #(
   parameter int unsigned         NUM_PIXELS = 196,
   parameter int unsigned         PIX_W      = 8,
   parameter int unsigned         ADDR_W     = 8,
   parameter logic [PIX_W-1:0]    LFSR_SEED  = 8'hA5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pix_rd_en_o,
   output logic [ADDR_W-1:0] pix_addr_o,
   input  logic [PIX_W-1:0]  pix_data_i,
   output logic              spike_valid_o,
   output logic              spike_data_o,
   output logic [ADDR_W-1:0] spike_idx_o,
   input  logic              spike_ready_i,
   output logic [ADDR_W-1:0] spike_count_o
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_PIXELS - 1);

   typedef enum logic [2:0] {StIdle, StFetch, StWait, StEmit, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [PIX_W-1:0]  lfsr_q, lfsr_d;
   logic              spike_q, spike_d;
   logic              lfsr_fb;

   // Taps for x^8+x^6+x^5+x^4+1, Fibonacci form shifting towards the MSB.
   assign lfsr_fb = lfsr_q[PIX_W-1] ^ lfsr_q[PIX_W-3] ^ lfsr_q[PIX_W-4] ^ lfsr_q[PIX_W-5];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         cnt_q   <= '0;
         lfsr_q  <= LFSR_SEED;
         spike_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         spike_q <= spike_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      spike_d = spike_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               idx_d   = '0;
               cnt_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: state_d = StWait;
         StWait: begin
            spike_d = (lfsr_q <= pix_data_i);
            state_d = StEmit;
         end
         StEmit: begin
            // Everything, including the LFSR, holds while the queue stalls.
            if (spike_ready_i) begin
               lfsr_d = {lfsr_q[PIX_W-2:0], lfsr_fb};
               cnt_d  = cnt_q + ADDR_W'(spike_q);
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = StFetch;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign busy_o        = (state_q != StIdle);
   assign done_o        = (state_q == StDone);
   assign pix_rd_en_o   = (state_q == StFetch);
   assign pix_addr_o    = idx_q;
   assign spike_valid_o = (state_q == StEmit);
   assign spike_data_o  = spike_q;
   assign spike_idx_o   = idx_q;
   assign spike_count_o = cnt_q;

endmodule
